// File: rtl/ps2_key_state_tracker.sv
// PS/2 scancode set 2 decoder tracking which of 16 piano keys are held, with an idle watchdog.
// Optional feature: define EXTENDED_FILTER_EN to discard E0-prefixed codes instead of aliasing them.
module ps2_key_state_tracker #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [7:0]  scancode_byte,
    input  logic        scancode_valid,
    output logic [16:0] key_state,
    output logic        key_event_valid,
    output logic [4:0]  key_event_index,
    output logic        key_event_pressed,
    output logic        timeout_flag
);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    // Make codes packed lowest-index first: byte gi-1 maps to key_state bit gi.
    localparam logic [8*16-1:0] KEY_CODES = {
        8'h5D, 8'h5B, 8'h29, 8'h42, 8'h3B, 8'h3C, 8'h33, 8'h35,
        8'h34, 8'h2C, 8'h2B, 8'h23, 8'h24, 8'h1B, 8'h1D, 8'h1C
    };

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [16:1]   keys_reg, keys_next;
    logic          no_press_reg, no_press_next;
    logic          ev_valid_reg, ev_valid_next;
    logic [4:0]    ev_index_reg, ev_index_next;
    logic          ev_pressed_reg, ev_pressed_next;
    logic          timeout_reg, timeout_next;

    logic [16:1]   hit;
    logic [4:0]    hit_index;
    logic          do_make;
    logic          do_break;

    generate
        for (genvar gi = 1; gi <= 16; gi++) begin : g_match
            assign hit[gi] = (scancode_byte == KEY_CODES[(gi-1)*8 +: 8]);
        end
    endgenerate

    always_comb begin
        hit_index = '0;
        for (int i = 1; i <= 16; i++) begin
            if (hit[i]) hit_index = 5'(i);
        end
    end

    // The byte following a prefix is either dropped (filter) or folded onto the plain paths.
    always_comb begin
`ifdef EXTENDED_FILTER_EN
        do_make  = (state_reg == IDLE);
        do_break = (state_reg == BRK);
`else
        do_make  = (state_reg == IDLE) || (state_reg == EXT);
        do_break = (state_reg == BRK)  || (state_reg == EXT_BRK);
`endif
    end

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        keys_next       = keys_reg;
        ev_valid_next   = 1'b0;
        ev_index_next   = '0;
        ev_pressed_next = 1'b0;
        timeout_next    = 1'b0;

        if (scancode_valid) begin
            count_next = '0;
            state_next = IDLE;
            if (scancode_byte == 8'hF0) begin
                if (state_reg == IDLE)     state_next = BRK;
                else if (state_reg == EXT) state_next = EXT_BRK;
            end else if (scancode_byte == 8'hE0 && state_reg == IDLE) begin
                state_next = EXT;
            end

            // Typematic repeats and breaks of unheld keys fall through without an event.
            if (do_make && |(hit & ~keys_reg)) begin
                keys_next       = keys_reg | hit;
                ev_valid_next   = 1'b1;
                ev_index_next   = hit_index;
                ev_pressed_next = 1'b1;
            end else if (do_break && |(hit & keys_reg)) begin
                keys_next       = keys_reg & ~hit;
                ev_valid_next   = 1'b1;
                ev_index_next   = hit_index;
                ev_pressed_next = 1'b0;
            end
        end else if (keys_reg == '0) begin
            count_next = '0;
        end else if (count_reg == COUNT_LAST) begin
            count_next   = '0;
            keys_next    = '0;
            timeout_next = 1'b1;
            state_next   = IDLE;
        end else begin
            count_next = count_reg + 1'b1;
        end

        no_press_next = ~|keys_next;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            keys_reg       <= '0;
            no_press_reg   <= 1'b1;
            ev_valid_reg   <= 1'b0;
            ev_index_reg   <= '0;
            ev_pressed_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            keys_reg       <= keys_next;
            no_press_reg   <= no_press_next;
            ev_valid_reg   <= ev_valid_next;
            ev_index_reg   <= ev_index_next;
            ev_pressed_reg <= ev_pressed_next;
            timeout_reg    <= timeout_next;
        end
    end

    assign key_state         = {keys_reg, no_press_reg};
    assign key_event_valid   = ev_valid_reg;
    assign key_event_index   = ev_index_reg;
    assign key_event_pressed = ev_pressed_reg;
    assign timeout_flag      = timeout_reg;

endmodule
